axi4_arw_split_bridge: RTL and testbench
========================================

Name: axi4_arw_split_bridge

Overview:
- Sits between the CPU crossbar's AXI4 RAM port and the DDR SDRAM controller.
- The crossbar side uses a shared read/write address channel (ARW + write flag). The controller side has separate AW/AR channels and no ID signals.
- The bridge registers each command, routes it to AW or AR, and owns the transaction ID.
- It allows exactly one outstanding transaction and generates WLAST from its own beat counter.

Parameters:
S_ADDR_W, 28, slave-side address width
M_ADDR_W, 26, master-side address width; lower bits of the slave address are forwarded
ID_W, 1, transaction ID width
DATA_W, 32, data width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
s_arw_valid/s_arw_ready  in/out  1/1  shared command handshake
s_arw_addr  in  S_ADDR_W  byte address
s_arw_id  in  ID_W  transaction ID
s_arw_len  in  8  burst length minus 1
s_arw_write  in  1  1 = write, 0 = read
s_w_valid/s_w_ready  in/out  1/1  write data handshake
s_w_data  in  DATA_W  write data
s_w_last  in  1  upstream last flag (checked only)
s_b_valid/s_b_ready  out/in  1/1  write response handshake
s_b_id  out  ID_W  latched ID
s_r_valid/s_r_ready  out/in  1/1  read data handshake
s_r_data  out  DATA_W  read data
s_r_id  out  ID_W  latched ID
s_r_last  out  1  read last
m_awvalid/m_awready  out/in  1/1  write address handshake
m_awaddr  out  M_ADDR_W  write address
m_awlen  out  8  write burst length
m_arvalid/m_arready  out/in  1/1  read address handshake
m_araddr  out  M_ADDR_W  read address
m_arlen  out  8  read burst length
m_wvalid/m_wready  out/in  1/1  write data handshake
m_wdata  out  DATA_W  write data
m_wlast  out  1  write last
m_bvalid/m_bready  in/out  1/1  write response handshake
m_rvalid/m_rready  in/out  1/1  read data handshake
m_rdata  in  DATA_W  read data
m_rlast  in  1  read last
busy  out  1  state != IDLE
err_len  out  1  sticky: s_w_last disagreed with the beat count

Behaviour:
- States and transitions:
  - IDLE -> on s_arw_valid & s_arw_ready, go to WADDR if write, else RADDR.
  - WADDR -> WDATA on m_awready.
  - WDATA -> WRESP on the final W handshake.
  - WRESP -> IDLE on s_b handshake.
  - RADDR -> RDATA on m_arready.
  - RDATA -> IDLE on an R handshake with m_rlast=1.
- s_arw_ready = (state==IDLE), combinational.
- On acceptance, latch addr, len, id and the write flag.
- m_awvalid / m_arvalid:
  - Asserted from the cycle after acceptance and held until m_*ready.
  - Address = latched addr[M_ADDR_W-1:0]; len = latched len.
  - Address and len stay stable while valid is high.
- Write data:
  - m_wvalid = s_w_valid & (state==WDATA); s_w_ready = m_wready & (state==WDATA).
  - W is never forwarded before AW has been accepted.
  - m_wdata = s_w_data.
- Beat counter:
  - 8-bit, cleared on entry to WDATA, incremented per W handshake.
  - m_wlast = (count == latched len).
  - len=0 gives a single beat with m_wlast=1.
  - len=255 gives 256 beats with no counter wrap issue; the compare uses 8 bits.
- err_len is set on any W handshake where s_w_last != m_wlast. The burst still completes on the counter. err_len is cleared only by reset.
- Write response:
  - s_b_valid = m_bvalid & (state==WRESP); m_bready = s_b_ready & (state==WRESP).
  - s_b_id = latched id.
- Read data:
  - s_r_valid = m_rvalid & (state==RDATA); m_rready = s_r_ready & (state==RDATA).
  - s_r_data = m_rdata; s_r_last = m_rlast; s_r_id = latched id.
- Outside the matching state, every pass-through valid/ready output is 0.
- A new command is not accepted in the cycle the previous transaction completes. Minimum gap: one cycle in IDLE.
- Reset, including mid-burst:
  - state=IDLE, all valid/ready outputs 0 except s_arw_ready=1.
  - Counter = 0, err_len = 0, latched fields = 0.
  - In-flight transactions are abandoned; this is system-wide reset only.

Test Plan:
- Write, addr 0x0000100, len=3, id=1, W always valid, slave always ready:
  - Required: m_awaddr=0x100 and m_awlen=3 one cycle after acceptance.
  - Required: 4 W beats, m_wlast only on the 4th; s_b_id=1; busy drops after the B handshake.
- Read, addr 0x3FFFFFC, len=7, id=0:
  - Required: m_araddr=0x3FFFFFC, 8 R beats forwarded with s_r_id=0, s_r_last on the 8th; then IDLE.
- Backpressure: m_awready held low 5 cycles, s_w_valid high throughout:
  - Required: zero W handshakes until AW completes.
  - Random m_wready/s_r_ready toggling: no data lost or duplicated (scoreboard).
- Len mismatch: len=1 with upstream s_w_last asserted on beat 0:
  - Required: err_len=1 after beat 0, burst still issues 2 beats, m_wlast on beat 1; err_len stays 1 until reset.
- s_arw_valid held high across back-to-back commands:
  - Required: s_arw_ready=0 while busy and at least one IDLE cycle between transactions.
- Reset asserted during beat 2 of an 8-beat write:
  - Required: next cycle state=IDLE, m_wvalid=0, s_arw_ready=1, err_len=0.
  - Required: a following read completes normally.

Source files
------------

// File: rtl/axi4_arw_split_bridge.sv
// axi4_arw_split_bridge: shared ARW command to split AW/AR with one outstanding transaction and local WLAST
module axi4_arw_split_bridge #(
  parameter int S_ADDR_W = 28,
  parameter int M_ADDR_W = 26,
  parameter int ID_W = 1,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_arw_valid,
  output logic                s_arw_ready,
  input  logic [S_ADDR_W-1:0] s_arw_addr,
  input  logic [ID_W-1:0]     s_arw_id,
  input  logic [7:0]          s_arw_len,
  input  logic                s_arw_write,
  input  logic                s_w_valid,
  output logic                s_w_ready,
  input  logic [DATA_W-1:0]   s_w_data,
  input  logic                s_w_last,
  output logic                s_b_valid,
  input  logic                s_b_ready,
  output logic [ID_W-1:0]     s_b_id,
  output logic                s_r_valid,
  input  logic                s_r_ready,
  output logic [DATA_W-1:0]   s_r_data,
  output logic [ID_W-1:0]     s_r_id,
  output logic                s_r_last,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [M_ADDR_W-1:0] m_awaddr,
  output logic [7:0]          m_awlen,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [M_ADDR_W-1:0] m_araddr,
  output logic [7:0]          m_arlen,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rlast,
  output logic                busy,
  output logic                err_len
);
  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;
  state_t state;
  logic [M_ADDR_W-1:0] addr_q;
  logic [7:0] len_q, cnt;
  logic [ID_W-1:0] id_q;
  logic unused_addr;
  assign unused_addr = ^s_arw_addr[S_ADDR_W-1:M_ADDR_W];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      id_q <= '0;
      cnt <= '0;
      err_len <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s_arw_valid) begin
          addr_q <= s_arw_addr[M_ADDR_W-1:0];
          len_q <= s_arw_len;
          id_q <= s_arw_id;
          state <= s_arw_write ? WADDR : RADDR;
        end
        WADDR: if (m_awready) begin
          cnt <= '0;
          state <= WDATA;
        end
        WDATA: if (s_w_valid && m_wready) begin
          cnt <= cnt + 8'd1;
          if (m_wlast) state <= WRESP;
          if (s_w_last != m_wlast) err_len <= 1'b1;
        end
        WRESP: if (m_bvalid && s_b_ready) state <= IDLE;
        RADDR: if (m_arready) state <= RDATA;
        RDATA: if (m_rvalid && s_r_ready && m_rlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign s_arw_ready = state == IDLE;
  assign busy = state != IDLE;
  assign m_awvalid = state == WADDR;
  assign m_awaddr = addr_q;
  assign m_awlen = len_q;
  assign m_arvalid = state == RADDR;
  assign m_araddr = addr_q;
  assign m_arlen = len_q;
  assign m_wvalid = s_w_valid && state == WDATA;
  assign s_w_ready = m_wready && state == WDATA;
  assign m_wdata = s_w_data;
  assign m_wlast = cnt == len_q;
  assign s_b_valid = m_bvalid && state == WRESP;
  assign m_bready = s_b_ready && state == WRESP;
  assign s_b_id = id_q;
  assign s_r_valid = m_rvalid && state == RDATA;
  assign m_rready = s_r_ready && state == RDATA;
  assign s_r_data = m_rdata;
  assign s_r_last = m_rlast;
  assign s_r_id = id_q;
endmodule

// File: tb/tb_axi4_arw_split_bridge.sv
// tb_axi4_arw_split_bridge: scoreboard bench with upstream W feeder and downstream DDR responder
module tb_axi4_arw_split_bridge;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic s_arw_valid = 0, s_arw_ready, s_arw_write = 0;
  logic [27:0] s_arw_addr = '0;
  logic [0:0] s_arw_id = '0, s_b_id, s_r_id;
  logic [7:0] s_arw_len = '0, m_awlen, m_arlen;
  logic s_w_valid = 0, s_w_ready, s_w_last = 0;
  logic [31:0] s_w_data = '0, s_r_data, m_wdata, m_rdata = '0;
  logic s_b_valid, s_b_ready = 1, s_r_valid, s_r_ready = 1, s_r_last;
  logic m_awvalid, m_awready = 1, m_arvalid, m_arready = 1;
  logic [25:0] m_awaddr, m_araddr;
  logic m_wvalid, m_wready = 1, m_wlast, m_bvalid = 1, m_bready;
  logic m_rvalid = 0, m_rready, m_rlast = 0, busy, err_len;

  axi4_arw_split_bridge dut (
    .clk(clk), .reset(reset),
    .s_arw_valid(s_arw_valid), .s_arw_ready(s_arw_ready), .s_arw_addr(s_arw_addr),
    .s_arw_id(s_arw_id), .s_arw_len(s_arw_len), .s_arw_write(s_arw_write),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_id(s_r_id),
    .s_r_last(s_r_last),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .busy(busy), .err_len(err_len)
  );

  int checks = 0, failures = 0;
  logic [33:0] aw_q[$], ar_q[$], r_q[$];
  logic [32:0] w_q[$];
  logic [0:0] b_q[$];
  bit aw_done = 1, rnd = 0;
  int aw_stall = 0;
  int w_left = 0, w_idx = 0, w_lastpos = 0;
  logic [25:0] w_ma = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [31:0] wdata_f(input logic [25:0] a, input int k);
    logic [7:0] kb = k[7:0];
    return {a[15:0], 8'h5A, kb};
  endfunction

  function automatic logic [31:0] rdata_f(input logic [25:0] a, input int k);
    return 32'hD000_0000 ^ {6'd0, a} ^ 32'(k);
  endfunction

  // upstream write-data source
  initial begin
    logic whs, rst_s;
    forever begin
      @(negedge clk);
      whs = s_w_valid & s_w_ready & !reset;
      rst_s = reset;
      @(posedge clk); #1;
      if (rst_s) w_left = 0;
      else if (whs) begin w_idx++; w_left--; end
      s_w_valid = w_left > 0;
      s_w_data = wdata_f(w_ma, w_idx);
      s_w_last = w_idx == w_lastpos;
    end
  end

  // downstream controller model
  initial begin
    logic ar_hs, r_hs, awv, rst_s;
    logic [25:0] ar_a, rd_a;
    logic [7:0] ar_l;
    int rd_left, rd_idx;
    rd_left = 0; rd_idx = 0; rd_a = '0;
    forever begin
      @(negedge clk);
      ar_hs = m_arvalid & m_arready & !reset;
      r_hs = m_rvalid & m_rready & !reset;
      awv = m_awvalid;
      ar_a = m_araddr;
      ar_l = m_arlen;
      rst_s = reset;
      @(posedge clk); #1;
      if (rst_s) rd_left = 0;
      else if (ar_hs) begin rd_left = int'(ar_l) + 1; rd_a = ar_a; rd_idx = 0; end
      else if (r_hs) begin rd_idx++; rd_left--; end
      m_rvalid = rd_left > 0;
      m_rdata = rdata_f(rd_a, rd_idx);
      m_rlast = rd_left == 1;
      if (awv && aw_stall > 0) aw_stall--;
      m_awready = aw_stall == 0;
      m_wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // scoreboard monitor
  initial begin
    logic [33:0] e34;
    logic [32:0] e33;
    logic [0:0] e1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("arw_ready_vs_busy", s_arw_ready, !busy);
        if (s_w_valid && !aw_done) chk("w_before_aw", m_wvalid, 0);
        if (m_awvalid && m_awready) begin
          if (aw_q.size() == 0) fail("aw_unexpected");
          else begin e34 = aw_q.pop_front(); chk("aw", {m_awaddr, m_awlen}, e34); end
          aw_done = 1;
        end
        if (m_arvalid && m_arready) begin
          if (ar_q.size() == 0) fail("ar_unexpected");
          else begin e34 = ar_q.pop_front(); chk("ar", {m_araddr, m_arlen}, e34); end
        end
        if (m_wvalid && m_wready) begin
          chk("w_ready", s_w_ready, 1);
          if (w_q.size() == 0) fail("w_unexpected");
          else begin e33 = w_q.pop_front(); chk("w", {m_wdata, m_wlast}, e33); end
        end
        if (s_b_valid && s_b_ready) begin
          chk("b_ready", m_bready, 1);
          if (b_q.size() == 0) fail("b_unexpected");
          else begin e1 = b_q.pop_front(); chk("b_id", s_b_id, e1); end
        end
        if (s_r_valid && s_r_ready) begin
          chk("r_ready", m_rready, 1);
          if (r_q.size() == 0) fail("r_unexpected");
          else begin e34 = r_q.pop_front(); chk("r", {s_r_data, s_r_id, s_r_last}, e34); end
        end
      end
    end
  end

  task automatic issue(input logic [27:0] a, input logic [7:0] l, input logic id,
                       input logic wr, input int lastpos, input bit keep);
    logic [25:0] ma;
    bit acc;
    ma = a[25:0];
    acc = 0;
    if (wr) begin
      aw_q.push_back({ma, l});
      for (int k = 0; k <= int'(l); k++) w_q.push_back({wdata_f(ma, k), k == int'(l)});
      b_q.push_back(id);
      aw_done = 0;
    end else begin
      ar_q.push_back({ma, l});
      for (int k = 0; k <= int'(l); k++) r_q.push_back({rdata_f(ma, k), id, k == int'(l)});
    end
    @(posedge clk); #1;
    s_arw_valid = 1; s_arw_addr = a; s_arw_len = l; s_arw_id = id; s_arw_write = wr;
    if (wr) begin w_ma = ma; w_idx = 0; w_lastpos = lastpos; w_left = int'(l) + 1; end
    for (int n = 0; n < 500 && !acc; n++) begin
      @(negedge clk);
      acc = s_arw_ready;
    end
    if (!acc) fail("arw_accept_timeout");
    @(posedge clk); #1;
    if (!keep) s_arw_valid = 0;
    @(negedge clk);
    chk(wr ? "awvalid_after_accept" : "arvalid_after_accept", wr ? m_awvalid : m_arvalid, 1);
    chk(wr ? "awaddr_after_accept" : "araddr_after_accept", wr ? m_awaddr : m_araddr, ma);
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 0;
    for (int n = 0; n < 3000 && !idle; n++) begin
      @(negedge clk);
      idle = !busy;
    end
    if (!idle) fail({name, "_idle_timeout"});
    chk({name, "_queues_drained"}, aw_q.size() + ar_q.size() + w_q.size() + b_q.size() + r_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    bit hit;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arw_ready", s_arw_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_valids", {m_awvalid, m_arvalid, m_wvalid, s_b_valid, s_r_valid}, 0);
    chk("rst_readies", {s_w_ready, m_bready, m_rready}, 0);
    @(posedge clk); #1 reset = 0;

    issue(28'h0000100, 8'd3, 1'b1, 1'b1, 3, 0);
    wait_idle("write_len3");
    issue(28'h3FFFFFC, 8'd7, 1'b0, 1'b0, 0, 0);
    wait_idle("read_len7");

    aw_stall = 5;
    issue(28'hFABCDE0, 8'd2, 1'b0, 1'b1, 2, 0);
    wait_idle("aw_backpressure");
    rnd = 1;
    issue(28'h0001234, 8'd5, 1'b1, 1'b1, 5, 0);
    wait_idle("write_random_ready");
    issue(28'h0000040, 8'd4, 1'b1, 1'b0, 0, 0);
    wait_idle("read_random_ready");
    rnd = 0;
    chk("err_len_clean", err_len, 0);

    issue(28'h0000200, 8'd1, 1'b1, 1'b1, 0, 0);
    wait_idle("len_mismatch");
    chk("err_len_set", err_len, 1);
    issue(28'h0000300, 8'd0, 1'b0, 1'b1, 0, 0);
    wait_idle("write_len0");
    chk("err_len_sticky", err_len, 1);

    issue(28'h0000400, 8'd2, 1'b1, 1'b0, 0, 1);
    issue(28'h0000500, 8'd1, 1'b0, 1'b0, 0, 0);
    wait_idle("back_to_back");

    issue(28'h0000800, 8'd7, 1'b1, 1'b1, 7, 0);
    hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      hit = w_q.size() <= 6;
    end
    if (!hit) fail("beat2_timeout");
    chk("err_len_before_reset", err_len, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_m_wvalid", m_wvalid, 0);
    chk("midrst_arw_ready", s_arw_ready, 1);
    chk("midrst_err_len", err_len, 0);
    chk("midrst_busy", busy, 0);
    w_q.delete(); b_q.delete(); aw_done = 1;
    @(posedge clk); #1 reset = 0;
    issue(28'h0000600, 8'd3, 1'b1, 1'b0, 0, 0);
    wait_idle("read_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
